booth_pp_accum: RTL and testbench



---
 rtl/mul_pkg.sv | 27 ++
 rtl/booth_pp_group_add.sv | 46 ++++
 rtl/booth_pp_accum.sv | 112 +++++++++++
 tb/tb_booth_pp_accum.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared multiply-unit constants, accumulator state encoding and Booth partial-product indexing helpers.
package mul_pkg;

    localparam int unsigned NPP          = 17;
    localparam int unsigned PPW          = 34;
    localparam int unsigned PW           = 66;
    localparam int unsigned PP_PER_CYCLE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mul_state_e;

    // Global partial-product index of slot `slot` within accumulate group `grp`.
    function automatic int unsigned pp_index(input int unsigned grp,
                                             input int unsigned slot,
                                             input int unsigned per_cycle);
        return grp * per_cycle + slot;
    endfunction

    // Radix-4 weight: partial product i sits at 4^i.
    function automatic int unsigned pp_shift(input int unsigned idx);
        return 2 * idx;
    endfunction

endpackage

// File: rtl/booth_pp_group_add.sv
// Combinational adder for one group of Booth partial products, each sign-extended and weighted, plus the running sum.
module booth_pp_group_add
    import mul_pkg::*;
#(
    parameter int unsigned NPP          = mul_pkg::NPP,
    parameter int unsigned PPW          = mul_pkg::PPW,
    parameter int unsigned PW           = mul_pkg::PW,
    parameter int unsigned PP_PER_CYCLE = mul_pkg::PP_PER_CYCLE,
    parameter int unsigned GW           = 3
) (
    input  logic [NPP*PPW-1:0] pp_flat,
    input  logic [GW-1:0]      grp,
    input  logic [PW-1:0]      acc_in,
    output logic [PW-1:0]      sum_c
);

    localparam int unsigned FW = NPP * PPW;
    localparam int unsigned BW = $clog2(FW);

    logic [PW-1:0]  sum;
    logic [PPW-1:0] pp;
    logic [PW-1:0]  term;
    logic [BW-1:0]  base;
    int unsigned    idx;

    // Slots past the last partial product (short final group) contribute nothing.
    always_comb begin
        sum  = acc_in;
        pp   = '0;
        term = '0;
        base = '0;
        idx  = 0;
        for (int unsigned j = 0; j < PP_PER_CYCLE; j++) begin
            idx = pp_index(32'(grp), j, PP_PER_CYCLE);
            if (idx < NPP) begin
                base = BW'(idx * PPW);
                pp   = pp_flat[base +: PPW];
                term = {{(PW-PPW){pp[PPW-1]}}, pp};
                sum  = sum + (term << pp_shift(idx));
            end
        end
    end

    assign sum_c = sum;

endmodule

// File: rtl/booth_pp_accum.sv
// Multi-cycle reduction of the radix-4 Booth partial products into the full signed product,
// with valid/ready on both sides and a flush that cancels the in-flight operation.
module booth_pp_accum
    import mul_pkg::*;
#(
    parameter int unsigned NPP          = mul_pkg::NPP,
    parameter int unsigned PPW          = mul_pkg::PPW,
    parameter int unsigned PW           = mul_pkg::PW,
    parameter int unsigned PP_PER_CYCLE = mul_pkg::PP_PER_CYCLE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NPP*PPW-1:0] pp_flat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PW-1:0]      product,
    output logic               busy
);

    localparam int unsigned K  = (NPP + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
    localparam int unsigned GW = (K > 1) ? $clog2(K) : 1;

    mul_state_e         state, state_nxt;
    logic [NPP*PPW-1:0] pp_q;
    logic [PW-1:0]      acc, acc_nxt;
    logic [GW-1:0]      grp, grp_nxt;
    logic               pp_ld;
    logic [PW-1:0]      grp_sum_c;

    booth_pp_group_add #(
        .NPP          (NPP),
        .PPW          (PPW),
        .PW           (PW),
        .PP_PER_CYCLE (PP_PER_CYCLE),
        .GW           (GW)
    ) u_group_add (
        .pp_flat (pp_q),
        .grp     (grp),
        .acc_in  (acc),
        .sum_c   (grp_sum_c)
    );

    // Next-state logic; flush overrides everything, but a DONE handoff on the same edge still counts.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        grp_nxt   = grp;
        pp_ld     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_nxt = ACCUM;
                    pp_ld     = 1'b1;
                    acc_nxt   = '0;
                    grp_nxt   = '0;
                end
            end
            ACCUM: begin
                acc_nxt = grp_sum_c;
                if (grp == GW'(K - 1)) begin
                    state_nxt = DONE;
                    grp_nxt   = '0;
                end else begin
                    grp_nxt = grp + GW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
            pp_ld     = 1'b0;
            acc_nxt   = '0;
            grp_nxt   = '0;
        end
    end

    // Handshake flags are registered from the next state so they never depend on out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            grp       <= '0;
            pp_q      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            grp       <= grp_nxt;
            if (pp_ld) begin
                pp_q <= pp_flat;
            end
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_booth_pp_accum.sv
// Scoreboard bench for booth_pp_accum: per-scenario tasks push expected products on accept and compare on output.
module tb_booth_pp_accum;
    import mul_pkg::*;

    localparam int unsigned FW = NPP * PPW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] pp_flat;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    logic [PW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    booth_pp_accum #(
        .NPP          (NPP),
        .PPW          (PPW),
        .PW           (PW),
        .PP_PER_CYCLE (PP_PER_CYCLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp_flat   (pp_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] rand_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < FW; i++) f[i] = 1'($urandom_range(0, 1));
        return f;
    endfunction

    function automatic logic [FW-1:0] one_pp(input int idx, input logic [PPW-1:0] v);
        logic [FW-1:0] f;
        f = '0;
        f[idx*PPW +: PPW] = v;
        return f;
    endfunction

    // Reference: sum of sign-extended pp_i at weight 4^i, modulo 2^PW.
    function automatic logic [PW-1:0] model(input logic [FW-1:0] pf);
        logic [PW-1:0]  s;
        logic [PPW-1:0] p;
        s = '0;
        for (int i = 0; i < NPP; i++) begin
            p = pf[i*PPW +: PPW];
            s = s + ({{(PW-PPW){p[PPW-1]}}, p} << (2 * i));
        end
        return s;
    endfunction

    task automatic accept_op(input logic [FW-1:0] pf, input logic [PW-1:0] e, input bit push);
        @(negedge clk);
        pp_flat  = pf;
        in_valid = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        pp_flat  = rand_flat();
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic pop_exp(output logic [PW-1:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (product !== '0) begin n_fail++; $display("FAIL reset_product: got %h expected 0", product); end
    endtask

    task automatic test_unit();
        int edges;
        logic [PW-1:0] e;
        accept_op(one_pp(0, 34'd1), 66'h1, 1'b1);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL unit_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        wait_valid(edges);
        n_checks++; if (edges !== 5) begin n_fail++; $display("FAIL unit_latency: got %0d edges expected 5", edges); end
        pop_exp(e);
        n_checks++; if (product !== e) begin n_fail++; $display("FAIL unit_product: got %h expected %h", product, e); end
        handoff();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL unit_after_handoff: got busy=%b out_valid=%b in_ready=%b expected 0/0/1", busy, out_valid, in_ready); end
        n_checks++; if (product !== 66'h1) begin n_fail++; $display("FAIL unit_product_hold: got %h expected 1", product); end
    endtask

    task automatic test_boundaries();
        int edges;
        logic [PW-1:0] e;
        logic [FW-1:0] ones;
        ones = '0;
        for (int i = 0; i < NPP; i++) ones[i*PPW +: PPW] = 34'd1;
        accept_op(one_pp(1, 34'h3_FFFF_FFFF), 66'h3_FFFF_FFFF_FFFF_FFFC, 1'b1);
        wait_valid(edges);
        pop_exp(e);
        n_checks++; if (edges !== 5 || product !== e) begin n_fail++; $display("FAIL neg_one: got %h after %0d edges expected %h after 5", product, edges, e); end
        handoff();
        accept_op(ones, 66'h1_5555_5555, 1'b1);
        wait_valid(edges);
        pop_exp(e);
        n_checks++; if (edges !== 5 || product !== e) begin n_fail++; $display("FAIL all_ones: got %h after %0d edges expected %h after 5", product, edges, e); end
        handoff();
        accept_op(one_pp(16, 34'h2_0000_0000), 66'h2_0000_0000_0000_0000, 1'b1);
        wait_valid(edges);
        pop_exp(e);
        n_checks++; if (edges !== 5 || product !== e) begin n_fail++; $display("FAIL min_pp16: got %h after %0d edges expected %h after 5", product, edges, e); end
        handoff();
    endtask

    task automatic test_back_to_back();
        int edges;
        logic [PW-1:0] e;
        logic [FW-1:0] pf;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            pf = rand_flat();
            accept_op(pf, model(pf), 1'b1);
            wait_valid(edges);
            pop_exp(e);
            n_checks++; if (edges !== 5 || product !== e) begin n_fail++; $display("FAIL b2b_product[%0d]: got %h after %0d edges expected %h", n, product, edges, e); end
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_return[%0d]: got in_ready=%b out_valid=%b expected 1/0", n, in_ready, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int edges;
        logic [PW-1:0] e;
        logic [FW-1:0] pf;
        pf = rand_flat();
        accept_op(pf, model(pf), 1'b1);
        wait_valid(edges);
        pop_exp(e);
        n_checks++; if (edges !== 5) begin n_fail++; $display("FAIL bp_latency: got %0d edges expected 5", edges); end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            pp_flat  = rand_flat();
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (product !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got product=%h out_valid=%b in_ready=%b expected %h/1/0", c, product, out_valid, in_ready, e); end
        end
        in_valid = 1'b0;
        handoff();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
    endtask

    task automatic test_flush();
        int edges;
        bit seen;
        logic [PW-1:0] e;
        logic [FW-1:0] pf;
        accept_op(rand_flat(), '0, 1'b0);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || product !== '0) begin n_fail++; $display("FAIL flush_accum: got busy=%b in_ready=%b product=%h expected 0/1/0", busy, in_ready, product); end
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_valid: got out_valid seen=%b expected 0", seen); end
        pp_flat  = rand_flat();
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_accept_drop: got busy=%b in_ready=%b expected 0/1", busy, in_ready); end
        pf = rand_flat();
        accept_op(pf, model(pf), 1'b1);
        wait_valid(edges);
        pop_exp(e);
        n_checks++; if (edges !== 5 || product !== e) begin n_fail++; $display("FAIL flush_done_product: got %h after %0d edges expected %h", product, edges, e); end
        out_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        flush     = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin n_fail++; $display("FAIL flush_done_idle: got out_valid=%b busy=%b product=%h expected 0/0/0", out_valid, busy, product); end
        accept_op(one_pp(0, 34'd7), 66'd7, 1'b1);
        wait_valid(edges);
        pop_exp(e);
        n_checks++; if (edges !== 5 || product !== e) begin n_fail++; $display("FAIL flush_clean_op: got %h after %0d edges expected %h", product, edges, e); end
        handoff();
    endtask

    task automatic test_reset_mid();
        int edges;
        bit seen;
        logic [PW-1:0] e;
        accept_op(rand_flat(), '0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || product !== '0) begin n_fail++; $display("FAIL rst_mid: got busy=%b out_valid=%b in_ready=%b product=%h expected 0/0/1/0", busy, out_valid, in_ready, product); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (out_valid || busy) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet: got activity=%b expected 0", seen); end
        accept_op(one_pp(0, 34'd7), 66'd7, 1'b1);
        wait_valid(edges);
        pop_exp(e);
        n_checks++; if (edges !== 5 || product !== e) begin n_fail++; $display("FAIL rst_clean_op: got %h after %0d edges expected %h", product, edges, e); end
        handoff();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp_flat   = '0;
        test_reset();
        test_unit();
        test_boundaries();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
